aes128_dec_iter: RTL and testbench

Iterative AES-128 inverse cipher. It is the receive-side counterpart to the team's AES-128 encryption core: it accepts one 128-bit ciphertext block plus cipher key and returns the FIPS-197 plaintext. One round runs per clock, and the round keys are regenerated on the fly (forward expansion to K10, then inverse key schedule), so no round-key RAM is needed. It sits behind the encryption datapath in loopback and self-check configurations.

---
 rtl/aes128_dec_iter.sv | 215 +++++++++++++++++++++
 tb/tb_aes128_dec_iter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_dec_iter.sv
// aes128_dec_iter: iterative AES-128 inverse cipher with on-the-fly round keys; optional K10 cache (AES_DEC_KEY_CACHE_EN).
// Latency: 21 cycles from accept to out_valid (11 on a key cache hit); one round per clock.
// Backpressure: result held in HOLD until out_ready; in_ready is high only in IDLE.
module aes128_dec_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt
);
  typedef enum logic [2:0] {IDLE, KEXP, ARK, ROUND, HOLD} fsm_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and 0 stays 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a14, a15, a30, a60, a120, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a14  = gf_mul(a12, a2);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    return gf_mul(a240, a14);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
            gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
            gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
            gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d, rk_q, rk_d;
  logic [3:0]   cnt_q, cnt_d, rcon_idx;
  logic [31:0]  sw_in, sw_out;
  logic [127:0] rk_fwd, rk_inv, sr, t, mc, k10_cached;
  logic         hit;

  // One bank of four forward S-boxes serves both key schedule directions.
  always_comb begin
    sw_in    = (fsm_q == KEXP) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
    rcon_idx = (fsm_q == ARK) ? 4'd10 : cnt_q;
    sw_out   = {sbox_fwd(sw_in[23:16]), sbox_fwd(sw_in[15:8]), sbox_fwd(sw_in[7:0]),
                sbox_fwd(sw_in[31:24])} ^ {rcon(rcon_idx), 24'h0};
    rk_fwd[127:96] = rk_q[127:96] ^ sw_out;
    rk_fwd[95:64]  = rk_q[95:64] ^ rk_fwd[127:96];
    rk_fwd[63:32]  = rk_q[63:32] ^ rk_fwd[95:64];
    rk_fwd[31:0]   = rk_q[31:0] ^ rk_fwd[63:32];
    rk_inv[127:96] = rk_q[127:96] ^ sw_out;
    rk_inv[95:64]  = rk_q[95:64] ^ rk_q[127:96];
    rk_inv[63:32]  = rk_q[63:32] ^ rk_q[95:64];
    rk_inv[31:0]   = rk_q[31:0] ^ rk_q[63:32];
  end

  always_comb begin
    t  = '0;
    mc = '0;
    sr = inv_shift_rows(state_q);
    for (int i = 0; i < 16; i++)
      t[127-8*i -: 8] = sbox_inv(sr[127-8*i -: 8]) ^ rk_q[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
  end

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] k10c_q, k10c_d, tag_q, tag_d;
  logic         cv_q, cv_d;

  assign hit        = cv_q && (key == tag_q);
  assign k10_cached = k10c_q;

  // Tag is captured at accept since key may change before K10 is ready.
  always_comb begin
    k10c_d = k10c_q;
    tag_d  = tag_q;
    cv_d   = cv_q;
    if (fsm_q == IDLE && in_valid && !hit) begin
      tag_d = key;
      cv_d  = 1'b0;
    end else if (fsm_q == KEXP && cnt_q == 4'd10) begin
      k10c_d = rk_fwd;
      cv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k10c_q <= '0;
      tag_q  <= '0;
      cv_q   <= 1'b0;
    end else begin
      k10c_q <= k10c_d;
      tag_q  <= tag_d;
      cv_q   <= cv_d;
    end
  end
`else
  assign hit        = 1'b0;
  assign k10_cached = '0;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        state_d = ct;
        cnt_d   = 4'd1;
        rk_d    = hit ? k10_cached : key;
        fsm_d   = hit ? ARK : KEXP;
      end
      KEXP: begin
        rk_d  = rk_fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) fsm_d = ARK;
      end
      ARK: begin
        state_d = state_q ^ rk_q;
        rk_d    = rk_inv;
        cnt_d   = 4'd9;
        fsm_d   = ROUND;
      end
      ROUND: begin
        if (cnt_q != 4'd0) begin
          state_d = mc;
          rk_d    = rk_inv;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = t;
          fsm_d   = HOLD;
        end
      end
      HOLD: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == HOLD);
  assign pt        = state_q;
endmodule

// File: tb/tb_aes128_dec_iter.sv
// Directed bench for aes128_dec_iter: FIPS vectors, cache latency, backpressure, mid-run reset, loopback.
module tb_aes128_dec_iter;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] key, ct, pt;
  int           n_chk = 0;
  int           n_fail = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KL = 128'habcdef1212345678aabbccdd11223344;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int LAT_HIT = 11;
`else
  localparam int LAT_HIT = 21;
`endif

  typedef struct {
    logic [127:0] k;
    logic [127:0] c;
    logic [127:0] p;
    int           lat;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] sbox_t [256];
  logic [7:0] rcon_t [11];

  always #5 clk = ~clk;

  aes128_dec_iter dut (
    .clk(clk), .rst(rst), .key(key), .in_valid(in_valid), .in_ready(in_ready),
    .ct(ct), .out_valid(out_valid), .out_ready(out_ready), .pt(pt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box table built by brute-force inverse search.
  task automatic build_tables();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    rcon_t[0] = 8'h00; rcon_t[1] = 8'h01; rcon_t[2] = 8'h02; rcon_t[3] = 8'h04;
    rcon_t[4] = 8'h08; rcon_t[5] = 8'h10; rcon_t[6] = 8'h20; rcon_t[7] = 8'h40;
    rcon_t[8] = 8'h80; rcon_t[9] = 8'h1b; rcon_t[10] = 8'h36;
  endtask

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] rk, s, t;
    logic [31:0]  w;
    rk = k;
    s  = p ^ k;
    for (int r = 1; r <= 10; r++) begin
      w = rk[31:0];
      w = {sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]], sbox_t[w[31:24]]} ^ {rcon_t[r], 24'h0};
      rk[127:96] = rk[127:96] ^ w;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          t[127-8*(4*c+rw) -: 8] = sbox_t[s[127-8*(4*((c+rw)%4)+rw) -: 8]];
      if (r != 10)
        for (int c = 0; c < 4; c++) t[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
      s = t ^ rk;
    end
    return s;
  endfunction

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid after consume"}, out_valid, 1'b0);
    check({name, " in_ready after consume"}, in_ready, 1'b1);
  endtask

  task automatic run_block(input string name, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] p_exp, input int lat_exp);
    int n;
    @(negedge clk);
    check({name, " in_ready idle"}, in_ready, 1'b1);
    key = k; ct = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    key = ~k; ct = ~c;
    check({name, " in_ready busy"}, in_ready, 1'b0);
    wait_out(n);
    check({name, " latency"}, 128'(n), 128'(lat_exp));
    check({name, " pt"}, pt, p_exp);
    consume(name);
  endtask

  initial begin
    int n;
    logic [127:0] p;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key = '0; ct = '0;
    build_tables();
    vecs[0] = '{K1, C1, P1, 21};
    vecs[1] = '{K1, C1, P1, LAT_HIT};
    vecs[2] = '{KB, CB, PB, 21};
    vecs[3] = '{KB, CB, PB, LAT_HIT};

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset pt", pt, '0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("reset in_ready", in_ready, 1'b1);

    for (int i = 0; i < 4; i++)
      run_block($sformatf("vec%0d", i), vecs[i].k, vecs[i].c, vecs[i].p, vecs[i].lat);

    // Backpressure: held result, new request ignored until after consumption.
    @(negedge clk);
    key = K1; ct = C1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(n);
    check("bp latency", 128'(n), 128'd21);
    key = KB; ct = CB; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold pt %0d", i), pt, P1);
      check($sformatf("bp hold in_ready %0d", i), in_ready, 1'b0);
      check($sformatf("bp hold out_valid %0d", i), out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp consumed out_valid", out_valid, 1'b0);
    check("bp not accepted in hold", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp accepted next cycle", in_ready, 1'b0);
    wait_out(n);
    check("bp second latency", 128'(n), 128'd21);
    check("bp second pt", pt, PB);
    consume("bp second");

    // Mid-operation reset, with the cache primed by a completed run first.
    run_block("pre-reset", K1, C1, P1, 21);
    @(negedge clk);
    key = K1; ct = C1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset pt", pt, '0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("midreset in_ready", in_ready, 1'b1);
    run_block("post-reset", K1, C1, P1, 21);

    // Loopback through the reference encryption model.
    for (int i = 0; i < 32; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("loop%0d", i), KL, aes_enc(KL, p), p, (i == 0) ? 21 : LAT_HIT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
